// File: rtl/nonce_dispatch_ctrl.sv
// Nonce lane scheduler: dispatches NUM_ENG nonce lanes per batch, collects results, rolls time/version.
// Optional WAIT_RETRY_EN: WAIT watchdog re-dispatches the same batch after WAIT_TIMEOUT cycles.
module nonce_dispatch_ctrl #(
  parameter int unsigned NUM_ENG       = 3,
  parameter int unsigned TIME_ROLL_MAX = 8,
  parameter int unsigned WAIT_TIMEOUT  = 16
) (
  input  logic                   sec_tick_clk,
  input  logic                   rst,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [31:0]            job_time,
  input  logic [31:0]            job_nonce,
  input  logic                   sec_tick,
  output logic                   eng_start,
  output logic [NUM_ENG*32-1:0]  eng_nonce,
  output logic [31:0]            eng_time,
  input  logic [NUM_ENG-1:0]     eng_done,
  input  logic [NUM_ENG-1:0]     eng_found,
  output logic                   found_valid,
  output logic [((NUM_ENG > 1) ? $clog2(NUM_ENG) : 1)-1:0] found_eng,
  output logic [31:0]            found_nonce,
  output logic [31:0]            found_time,
  input  logic                   found_ack,
  output logic                   inc_vrn_flg,
  output logic                   busy
);

  localparam int unsigned EW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
  localparam int unsigned RW = $clog2(TIME_ROLL_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DISPATCH, S_WAIT, S_ADVANCE, S_FOUND, S_VROLL
  } state_e;

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  state_e                 state_q;
  logic [31:0]            base_le_q;
  logic [31:0]            time_q;
  logic [RW-1:0]          roll_cnt_q;
  logic                   tick_pend_q;
  logic [NUM_ENG-1:0]     done_mask_q;
  logic                   job_ready_q;
  logic                   eng_start_q;
  logic [NUM_ENG*32-1:0]  eng_nonce_q;
  logic [31:0]            eng_time_q;
  logic                   found_valid_q;
  logic [EW-1:0]          found_eng_q;
  logic [31:0]            found_nonce_q;
  logic [31:0]            found_time_q;
  logic                   inc_vrn_q;
  logic                   busy_q;
`ifdef WAIT_RETRY_EN
  localparam int unsigned WW = $clog2(WAIT_TIMEOUT + 1);
  logic [WW-1:0]          wd_q;
`endif

  logic [NUM_ENG-1:0]     found_now;
  logic [NUM_ENG-1:0]     mask_d;
  logic [EW-1:0]          win_idx_d;
  logic [31:0]            win_nonce_d;
  logic                   hit;
  logic [32:0]            base_sum_d;
  logic [RW-1:0]          roll_d;
  logic [31:0]            time_inc_d;

  always_comb begin
    found_now   = eng_done & eng_found;
    mask_d      = done_mask_q | eng_done;
    win_idx_d   = '0;
    win_nonce_d = eng_nonce_q[31:0];
    hit         = 1'b0;
    for (int unsigned i = 0; i < NUM_ENG; i++) begin
      if (found_now[i] && !hit) begin
        hit         = 1'b1;
        win_idx_d   = EW'(i);
        win_nonce_d = eng_nonce_q[32*i +: 32];
      end
    end
    // Carry out of bit 31 means the next stride would pass 32'hFFFF_FFFF.
    base_sum_d = {1'b0, base_le_q} + 33'(NUM_ENG);
    roll_d     = roll_cnt_q + 1'b1;
    time_inc_d = swap32(swap32(time_q) + 32'd1);
  end

  always_ff @(posedge sec_tick_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      base_le_q     <= '0;
      time_q        <= '0;
      roll_cnt_q    <= '0;
      tick_pend_q   <= 1'b0;
      done_mask_q   <= '0;
      job_ready_q   <= 1'b1;
      eng_start_q   <= 1'b0;
      eng_nonce_q   <= '0;
      eng_time_q    <= '0;
      found_valid_q <= 1'b0;
      found_eng_q   <= '0;
      found_nonce_q <= '0;
      found_time_q  <= '0;
      inc_vrn_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef WAIT_RETRY_EN
      wd_q          <= '0;
`endif
    end else begin
      eng_start_q <= 1'b0;
      tick_pend_q <= tick_pend_q | sec_tick;
      case (state_q)
        S_IDLE, S_VROLL: begin
          if (job_valid) begin
            base_le_q   <= swap32(job_nonce);
            time_q      <= job_time;
            roll_cnt_q  <= '0;
            inc_vrn_q   <= 1'b0;
            job_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_LOAD;
          end
        end
        S_LOAD: begin
          for (int unsigned i = 0; i < NUM_ENG; i++)
            eng_nonce_q[32*i +: 32] <= swap32(base_le_q + 32'(i));
          eng_time_q <= time_q;
          state_q    <= S_DISPATCH;
        end
        S_DISPATCH: begin
          eng_start_q <= 1'b1;
          done_mask_q <= '0;
`ifdef WAIT_RETRY_EN
          wd_q        <= '0;
`endif
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          done_mask_q <= mask_d;
          if (|found_now) begin
            found_valid_q <= 1'b1;
            found_eng_q   <= win_idx_d;
            found_nonce_q <= win_nonce_d;
            found_time_q  <= eng_time_q;
            state_q       <= S_FOUND;
          end else if (&mask_d) begin
            state_q <= S_ADVANCE;
          end
`ifdef WAIT_RETRY_EN
          else if (wd_q == WW'(WAIT_TIMEOUT - 1)) begin
            state_q <= S_DISPATCH;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_ADVANCE: begin
          // A tick landing this very cycle stays pending for the next batch.
          tick_pend_q <= sec_tick;
          if (base_sum_d[32]) begin
            base_le_q  <= '0;
            time_q     <= time_inc_d;
            roll_cnt_q <= roll_d;
            if (roll_d == RW'(TIME_ROLL_MAX)) begin
              inc_vrn_q   <= 1'b1;
              job_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_VROLL;
            end else begin
              state_q <= S_LOAD;
            end
          end else begin
            base_le_q <= base_sum_d[31:0];
            if (tick_pend_q) time_q <= time_inc_d;
            state_q <= S_LOAD;
          end
        end
        S_FOUND: begin
          if (found_ack) begin
            found_valid_q <= 1'b0;
            job_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            state_q       <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign job_ready   = job_ready_q;
  assign eng_start   = eng_start_q;
  assign eng_nonce   = eng_nonce_q;
  assign eng_time    = eng_time_q;
  assign found_valid = found_valid_q;
  assign found_eng   = found_eng_q;
  assign found_nonce = found_nonce_q;
  assign found_time  = found_time_q;
  assign inc_vrn_flg = inc_vrn_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_nonce_dispatch_ctrl.sv
// Scoreboard bench for nonce_dispatch_ctrl: expected batch starts and found results are queued
// by the stimulus and checked by a monitor; a second instance with TIME_ROLL_MAX=1 covers VROLL.
module tb_nonce_dispatch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic [31:0] job_time, job_nonce;
  logic        sec_tick;
  logic [2:0]  eng_done, eng_found;
  logic        found_ack;

  logic        job_ready, eng_start, found_valid, inc_vrn_flg, busy;
  logic [95:0] eng_nonce;
  logic [31:0] eng_time, found_nonce, found_time;
  logic [1:0]  found_eng;

  logic        v_job_ready, v_eng_start, v_found_valid, v_inc_vrn_flg, v_busy;
  logic [95:0] v_eng_nonce;
  logic [31:0] v_eng_time, v_found_nonce, v_found_time;
  logic [1:0]  v_found_eng;

  nonce_dispatch_ctrl dut (
    .sec_tick_clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_time(job_time), .job_nonce(job_nonce), .sec_tick(sec_tick),
    .eng_start(eng_start), .eng_nonce(eng_nonce), .eng_time(eng_time),
    .eng_done(eng_done), .eng_found(eng_found), .found_valid(found_valid),
    .found_eng(found_eng), .found_nonce(found_nonce), .found_time(found_time),
    .found_ack(found_ack), .inc_vrn_flg(inc_vrn_flg), .busy(busy)
  );

  nonce_dispatch_ctrl #(.TIME_ROLL_MAX(1)) dut_v (
    .sec_tick_clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(v_job_ready),
    .job_time(job_time), .job_nonce(job_nonce), .sec_tick(sec_tick),
    .eng_start(v_eng_start), .eng_nonce(v_eng_nonce), .eng_time(v_eng_time),
    .eng_done(eng_done), .eng_found(eng_found), .found_valid(v_found_valid),
    .found_eng(v_found_eng), .found_nonce(v_found_nonce), .found_time(v_found_time),
    .found_ack(found_ack), .inc_vrn_flg(v_inc_vrn_flg), .busy(v_busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned cyc; logic [95:0] lanes; logic [31:0] tm; } start_t;
  typedef struct { logic [1:0] eng; logic [31:0] nonce; logic [31:0] tm; } found_t;
  start_t sq[$];
  found_t fq[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Monitor: every eng_start and every rising found_valid consumes one expectation.
  logic fv_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) begin
        if (sq.size() == 0) begin
          chk("unexpected_start", 96'd1, 96'd0);
        end else begin
          start_t e;
          e = sq.pop_front();
          chk("start_cycle", 96'(cyc), 96'(e.cyc));
          chk("start_lanes", eng_nonce, e.lanes);
          chk("start_time", 96'(eng_time), 96'(e.tm));
        end
      end
      if (found_valid && !fv_prev) begin
        if (fq.size() == 0) begin
          chk("unexpected_found", 96'd1, 96'd0);
        end else begin
          found_t f;
          f = fq.pop_front();
          chk("found_eng", 96'(found_eng), 96'(f.eng));
          chk("found_nonce", 96'(found_nonce), 96'(f.nonce));
          chk("found_time", 96'(found_time), 96'(f.tm));
        end
      end
    end
    fv_prev = found_valid;
  end

  task automatic exp_start(input int unsigned c, input logic [95:0] l, input logic [31:0] t);
    start_t e;
    e.cyc = c; e.lanes = l; e.tm = t;
    sq.push_back(e);
  endtask

  task automatic exp_found(input logic [1:0] g, input logic [31:0] n, input logic [31:0] t);
    found_t f;
    f.eng = g; f.nonce = n; f.tm = t;
    fq.push_back(f);
  endtask

  task automatic pulse_job(input logic [31:0] t, input logic [31:0] n);
    job_time = t; job_nonce = n; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [2:0] d, input logic [2:0] f);
    eng_done = d; eng_found = f;
    @(negedge clk);
    eng_done = '0; eng_found = '0;
  endtask

  task automatic pulse_ack();
    found_ack = 1'b1;
    @(negedge clk);
    found_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_time = '0; job_nonce = '0;
    sec_tick = 1'b0; eng_done = '0; eng_found = '0; found_ack = 1'b0;
    @(negedge clk);
    chk("rst_job_ready", 96'(job_ready), 96'd1);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_eng_start", 96'(eng_start), 96'd0);
    chk("rst_eng_nonce", eng_nonce, 96'd0);
    chk("rst_found_valid", 96'(found_valid), 96'd0);
    chk("rst_inc_vrn", 96'(inc_vrn_flg), 96'd0);
    rst = 1'b0;
    @(negedge clk);

    // First job: start two cycles after accept.
    exp_start(cyc + 3, {32'h02000000, 32'h01000000, 32'h00000000}, 32'h10000000);
    pulse_job(32'h10000000, 32'h00000000);
    chk("busy_after_accept", 96'(busy), 96'd1);
    chk("ready_after_accept", 96'(job_ready), 96'd0);
    repeat (2) @(negedge clk);

    // All done, no found: stride by 3, start three cycles after last done.
    exp_start(cyc + 4, {32'h05000000, 32'h04000000, 32'h03000000}, 32'h10000000);
    pulse_done(3'b111, 3'b000);
    repeat (3) @(negedge clk);

    // Job while busy ignored; partial and repeated dones do not advance.
    pulse_job(32'hAAAAAAAA, 32'h12345678);
    pulse_done(3'b001, 3'b000);
    pulse_done(3'b001, 3'b000);
    pulse_done(3'b011, 3'b000);
    exp_start(cyc + 4, {32'h08000000, 32'h07000000, 32'h06000000}, 32'h10000000);
    pulse_done(3'b100, 3'b000);
    repeat (3) @(negedge clk);

    // Found completes the mask in the same cycle: found wins, lane 1 of base 6.
    pulse_done(3'b001, 3'b000);
    exp_found(2'd1, 32'h07000000, 32'h10000000);
    pulse_done(3'b110, 3'b110);
    repeat (2) @(negedge clk);
    chk("found_held", 96'(found_valid), 96'd1);
    chk("found_busy", 96'(busy), 96'd1);
    chk("found_not_ready", 96'(job_ready), 96'd0);
    pulse_ack();
    chk("ack_clears_valid", 96'(found_valid), 96'd0);
    chk("ack_ready", 96'(job_ready), 96'd1);
    chk("ack_idle_busy", 96'(busy), 96'd0);

    // Nonce overflow: lanes wrap to 0, time rolls once.
    exp_start(cyc + 3, {32'hFFFFFFFF, 32'hFEFFFFFF, 32'hFDFFFFFF}, 32'h10000000);
    pulse_job(32'h10000000, 32'hFDFFFFFF);
    repeat (2) @(negedge clk);
    exp_start(cyc + 4, {32'h02000000, 32'h01000000, 32'h00000000}, 32'h11000000);
    pulse_done(3'b111, 3'b000);
    repeat (3) @(negedge clk);
    chk("main_no_vroll", 96'(inc_vrn_flg), 96'd0);
    chk("v_inc_vrn", 96'(v_inc_vrn_flg), 96'd1);
    chk("v_vroll_busy", 96'(v_busy), 96'd0);
    chk("v_vroll_ready", 96'(v_job_ready), 96'd1);

    // VROLL takes a new job (main is busy and ignores it); flag clears.
    pulse_job(32'h00000000, 32'h00000000);
    chk("v_vroll_accept_flag", 96'(v_inc_vrn_flg), 96'd0);
    chk("v_vroll_accept_busy", 96'(v_busy), 96'd1);

    // Second tick during WAIT: time +1 on the next advance only.
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
    exp_start(cyc + 4, {32'h05000000, 32'h04000000, 32'h03000000}, 32'h12000000);
    pulse_done(3'b111, 3'b000);
    repeat (3) @(negedge clk);
    exp_start(cyc + 4, {32'h08000000, 32'h07000000, 32'h06000000}, 32'h12000000);
    pulse_done(3'b111, 3'b000);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-WAIT.
    #2 rst = 1'b1;
    #1;
    chk("arst_job_ready", 96'(job_ready), 96'd1);
    chk("arst_busy", 96'(busy), 96'd0);
    chk("arst_eng_nonce", eng_nonce, 96'd0);
    chk("arst_eng_time", 96'(eng_time), 96'd0);
    chk("arst_inc_vrn", 96'(v_inc_vrn_flg), 96'd0);
    @(negedge clk);
    pulse_done(3'b111, 3'b110);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_found", 96'(found_valid), 96'd0);

    // Fresh job; multiple found bits resolve to the lowest index.
    exp_start(cyc + 3, {32'h0C000000, 32'h0B000000, 32'h0A000000}, 32'h20000000);
    pulse_job(32'h20000000, 32'h0A000000);
    repeat (2) @(negedge clk);
    exp_found(2'd0, 32'h0A000000, 32'h20000000);
    pulse_done(3'b111, 3'b101);
    @(negedge clk);
    pulse_ack();
    chk("final_ready", 96'(job_ready), 96'd1);

    repeat (5) @(negedge clk);
    chk("start_queue_drained", 96'(sq.size()), 96'd0);
    chk("found_queue_drained", 96'(fq.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
